// File: rtl/mdu_instr_decoder_pkg.sv
// ============================================================================
// Module      : mdu_instr_decoder_pkg
// Description : Opcode/funct constants and MDU control codes for the E-stage
//               multiply/divide decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_instr_decoder_pkg;

    localparam logic [5:0] SPECIAL  = 6'b000000;

    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    localparam logic [3:0] WNONE    = 4'd0;
    localparam logic [3:0] WHI      = 4'd1;
    localparam logic [3:0] WLO      = 4'd2;

    localparam logic [3:0] NONE      = 4'd0;
    localparam logic [3:0] SIGN_MULT = 4'd1;
    localparam logic [3:0] ZERO_MULT = 4'd2;
    localparam logic [3:0] SIGN_DIV  = 4'd3;
    localparam logic [3:0] ZERO_DIV  = 4'd4;

    localparam logic [1:0] RNONE    = 2'd0;
    localparam logic [1:0] RHI      = 2'd1;
    localparam logic [1:0] RLO      = 2'd2;

endpackage : mdu_instr_decoder_pkg

`default_nettype wire

// File: rtl/mdu_instr_decoder.sv
// ============================================================================
// Module      : mdu_instr_decoder
// Description : Combinational E-stage decode of MDU instructions plus a sticky
//               flag recording reserved MDU-group funct encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_instr_decoder
    import mdu_instr_decoder_pkg::*;
#(
    parameter logic [5:0] OP_SPECIAL = SPECIAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    output logic [3:0]  MDUwrite,
    output logic [3:0]  MDUcal,
    output logic        start,
    output logic [1:0]  MDUread,
    output logic        use_mdu,
    output logic        ri,
    output logic        ri_seen
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ri_seen_q;
    logic       ri_seen_d;
    logic       unused_fields;

    assign opcode        = Instr[31:26];
    assign funct         = Instr[5:0];
    assign unused_fields = ^Instr[25:6];

    always_comb begin
        MDUwrite = WNONE;
        MDUcal   = NONE;
        MDUread  = RNONE;
        use_mdu  = 1'b0;
        ri       = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                F_MFHI:  begin MDUread  = RHI;       use_mdu = 1'b1; end
                F_MTHI:  begin MDUwrite = WHI;       use_mdu = 1'b1; end
                F_MFLO:  begin MDUread  = RLO;       use_mdu = 1'b1; end
                F_MTLO:  begin MDUwrite = WLO;       use_mdu = 1'b1; end
                F_MULT:  begin MDUcal   = SIGN_MULT; use_mdu = 1'b1; end
                F_MULTU: begin MDUcal   = ZERO_MULT; use_mdu = 1'b1; end
                F_DIV:   begin MDUcal   = SIGN_DIV;  use_mdu = 1'b1; end
                F_DIVU:  begin MDUcal   = ZERO_DIV;  use_mdu = 1'b1; end
                // Holes in the 0x10-0x1F MDU group are reserved encodings
                6'h14, 6'h15, 6'h16, 6'h17,
                6'h1C, 6'h1D, 6'h1E, 6'h1F: ri = 1'b1;
                default: ;
            endcase
        end
    end

    assign start = (MDUcal != NONE);

    always_comb begin
        ri_seen_d = ri_seen_q;
        if (ri) begin
            ri_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ri_seen_q <= 1'b0;
        end else begin
            ri_seen_q <= ri_seen_d;
        end
    end

    assign ri_seen = ri_seen_q;

endmodule : mdu_instr_decoder

`default_nettype wire

// File: tb/tb_mdu_instr_decoder.sv
// ============================================================================
// Module      : tb_mdu_instr_decoder
// Description : Self-checking bench for mdu_instr_decoder against an
//               arithmetic reference model of the instruction decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_instr_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  MDUwrite;
    logic [3:0]  MDUcal;
    logic        start;
    logic [1:0]  MDUread;
    logic        use_mdu;
    logic        ri;
    logic        ri_seen;

    int n_checks;
    int n_pass;

    // reference model state
    int m_write, m_cal, m_read, m_use, m_ri;
    int m_seen;

    mdu_instr_decoder #(.OP_SPECIAL(6'b000000)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr    (Instr),
        .MDUwrite (MDUwrite),
        .MDUcal   (MDUcal),
        .start    (start),
        .MDUread  (MDUread),
        .use_mdu  (use_mdu),
        .ri       (ri),
        .ri_seen  (ri_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (Instr=%08h)", tag, got, exp, Instr);
        end
    endtask

    // Decode from the instruction-set rules using plain arithmetic on funct.
    task automatic model(input logic [31:0] ins);
        int op, f;
        op = int'(ins >> 26);
        f  = int'(ins % 64);
        m_write = 0; m_cal = 0; m_read = 0; m_use = 0; m_ri = 0;
        if (op == 0) begin
            if (f >= 16 && f <= 19) begin
                m_use = 1;
                if (f % 2 == 0) m_read  = (f == 16) ? 1 : 2;
                else            m_write = (f == 17) ? 1 : 2;
            end else if (f >= 24 && f <= 27) begin
                m_use = 1;
                m_cal = f - 23;
            end else if ((f >= 20 && f <= 23) || (f >= 28 && f <= 31)) begin
                m_ri = 1;
            end
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic rst);
        int nxt;
        @(negedge clk);
        Instr = ins;
        reset = rst;
        #1;
        model(ins);
        check("MDUwrite", int'(MDUwrite), m_write);
        check("MDUcal",   int'(MDUcal),   m_cal);
        check("start",    int'(start),    (m_cal != 0) ? 1 : 0);
        check("MDUread",  int'(MDUread),  m_read);
        check("use_mdu",  int'(use_mdu),  m_use);
        check("ri",       int'(ri),       m_ri);
        nxt = rst ? 0 : (m_ri ? 1 : m_seen);
        @(posedge clk);
        #1;
        m_seen = nxt;
        check("ri_seen",  int'(ri_seen),  m_seen);
    endtask

    initial begin
        logic [31:0] ins;
        n_checks = 0;
        n_pass   = 0;
        m_seen   = 0;
        reset    = 1'b1;
        Instr    = 32'h0;
        @(posedge clk);
        #1;
        check("reset_ri_seen", int'(ri_seen), 0);

        step(32'h00850018, 1'b0);
        check("mult_cal", int'(MDUcal), 1);
        step(32'h00000019, 1'b0);
        step(32'h0000001A, 1'b0);
        step(32'h0000001B, 1'b0);
        check("divu_cal", int'(MDUcal), 4);
        step(32'h00200011, 1'b0);
        step(32'h00200013, 1'b0);
        step(32'h00001010, 1'b0);
        step(32'h00001012, 1'b0);
        check("mflo_read", int'(MDUread), 2);
        step(32'h8C850018, 1'b0);
        step(32'h00000021, 1'b0);
        check("sticky_clear", int'(ri_seen), 0);
        step(32'h00000014, 1'b0);
        check("sticky_set", int'(ri_seen), 1);
        step(32'h00000000, 1'b0);
        check("sticky_hold", int'(ri_seen), 1);
        step(32'h00000000, 1'b1);
        check("sticky_reset", int'(ri_seen), 0);
        step(32'h0000001F, 1'b1);
        check("reset_wins", int'(ri_seen), 0);
        step(32'h0000001C, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:26] = 6'b000000;
            if ($urandom_range(0, 2) != 0) ins[5:4]   = 2'b01;
            step(ins, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mdu_instr_decoder

`default_nettype wire
